// File: rtl/rom_burst_reader.sv
// Purpose : burst-copies a run-time number of words from a synchronous ROM into a register array, streaming each word out.
// Latency : first word appears on out_* RD_LAT+2 cycles after start is sampled, then one word per cycle; done with the last word.
// Backpressure: none; one address per cycle, and the consumer must accept out_valid whenever it strobes.
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   start, abort      begin a burst (IDLE/DONE only) / cancel; abort wins over start
//   base_addr, length burst base address and word count, sampled with start
//   rom_q_data_in     ROM read data, valid RD_LAT cycles after address
//   address           ROM address, holds last issued value outside ISSUE
//   busy, done        busy in ISSUE/DRAIN; done is a level held in DONE
//   out_valid/out_data/out_index  one-cycle strobe per captured word
//   rom_data          captured words, rom_data[i] = ROM[base+i]
module rom_burst_reader #(
    parameter int DEP    = 32,
    parameter int WID    = 8,
    parameter int AW     = 9,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [AW-1:0]              base_addr,
    input  logic [$clog2(DEP+1)-1:0]   length,
    input  logic [WID-1:0]             rom_q_data_in,
    output logic [AW-1:0]              address,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    output logic [WID-1:0]             out_data,
    output logic [$clog2(DEP)-1:0]     out_index,
    output logic [DEP-1:0][WID-1:0]    rom_data
);

    localparam int LW = $clog2(DEP + 1);
    localparam int IW = $clog2(DEP);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   issue_idx;     // array index of the address currently on the bus
    logic [LW-1:0]   burst_len;     // clamped length latched at start

    // One tag per outstanding read: travels alongside the ROM latency so the
    // capture point knows which index it is writing, independent of FSM state.
    logic            tag_vld  [RD_LAT];
    logic [IW-1:0]   tag_idx  [RD_LAT];
    logic            tag_last [RD_LAT];

    logic [LW-1:0]   len_clamped;
    logic            issue_last;
    logic            cap_vld;
    logic [IW-1:0]   cap_idx;
    logic            cap_last;

    always_comb begin
        len_clamped = length;
        if (length > LW'(DEP)) begin
            len_clamped = LW'(DEP);
        end
    end

    assign issue_last = (LW'(issue_idx) == (burst_len - LW'(1)));

    assign cap_vld  = tag_vld[RD_LAT-1];
    assign cap_idx  = tag_idx[RD_LAT-1];
    assign cap_last = tag_last[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            address   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            rom_data  <= '0;
            issue_idx <= '0;
            burst_len <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_vld[k]  <= 1'b0;
                tag_idx[k]  <= '0;
                tag_last[k] <= 1'b0;
            end
        end else begin
            // Tag pipeline; abort flushes every in-flight tag so nothing
            // arriving later from the ROM is captured.
            tag_vld[0]  <= (state == S_ISSUE) && !abort;
            tag_idx[0]  <= issue_idx;
            tag_last[0] <= issue_last;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_vld[k]  <= tag_vld[k-1] && !abort;
                tag_idx[k]  <= tag_idx[k-1];
                tag_last[k] <= tag_last[k-1];
            end

            // The word landing on the abort edge is still stored, but it is
            // not announced: no out_valid may follow an abort.
            out_valid <= 1'b0;
            if (cap_vld) begin
                rom_data[cap_idx] <= rom_q_data_in;
                if (!abort) begin
                    out_valid <= 1'b1;
                    out_data  <= rom_q_data_in;
                    out_index <= cap_idx;
                end
            end

            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            if (len_clamped == '0) begin
                                // Empty burst: straight to DONE, no ROM access.
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                state     <= S_ISSUE;
                                busy      <= 1'b1;
                                done      <= 1'b0;
                                address   <= base_addr;
                                issue_idx <= '0;
                                burst_len <= len_clamped;
                            end
                        end
                    end
                    S_ISSUE: begin
                        if (issue_last) begin
                            state <= S_DRAIN;
                        end else begin
                            address   <= address + AW'(1);
                            issue_idx <= issue_idx + IW'(1);
                        end
                    end
                    S_DRAIN: begin
                        // The last tag always reaches capture after ISSUE ends
                        // (RD_LAT >= 1), so only DRAIN needs to look for it.
                        if (cap_vld && cap_last) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
module tb_rom_burst_reader;

    localparam int DEP  = 32;
    localparam int WID  = 8;
    localparam int AW   = 9;
    localparam int LW   = $clog2(DEP + 1);
    localparam int IW   = $clog2(DEP);
    localparam int NI   = 3;          // instance g has RD_LAT = g+1
    localparam int NONE = 1000000;    // "no abort" cycle

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;

    logic [WID-1:0]            rom_q     [NI];
    logic [AW-1:0]             address   [NI];
    logic                      busy      [NI];
    logic                      done      [NI];
    logic                      out_valid [NI];
    logic [WID-1:0]            out_data  [NI];
    logic [IW-1:0]             out_index [NI];
    logic [DEP-1:0][WID-1:0]   rom_data  [NI];

    logic [DEP-1:0][WID-1:0]   exp_mem   [NI];
    logic [AW-1:0]             exp_addr  [NI];

    int errors;
    int checks;
    int cur_lat;
    int cur_cyc;

    always #5 clk = ~clk;

    function automatic logic [WID-1:0] rom_fn(input logic [AW-1:0] a);
        return a[WID-1:0] ^ 8'hA5;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [WID-1:0] rq [g+1];

        always @(posedge clk) begin
            rq[0] <= rom_fn(address[g]);
            for (int k = 1; k < g + 1; k++) begin
                rq[k] <= rq[k-1];
            end
        end

        assign rom_q[g] = rq[g];

        rom_burst_reader #(
            .DEP(DEP), .WID(WID), .AW(AW), .RD_LAT(g + 1)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .start         (start),
            .abort         (abort),
            .base_addr     (base_addr),
            .length        (length),
            .rom_q_data_in (rom_q[g]),
            .address       (address[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .out_valid     (out_valid[g]),
            .out_data      (out_data[g]),
            .out_index     (out_index[g]),
            .rom_data      (rom_data[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lat=%0d cyc=%0d got=%0h exp=%0h", tag, cur_lat, cur_cyc, got, exp);
        end
    endtask

    // Start a burst in cycle 0 and check every cycle afterwards. ab is the
    // cycle in which abort is high (NONE for none); hold keeps start high with
    // junk base/length while every instance is still busy.
    task automatic run_burst(input logic [AW-1:0] base, input int len, input int ab, input bit hold);
        int L;
        int m;
        int lat;
        int t;
        int i;
        bit v;
        logic [AW-1:0] ea;
        L = (len > DEP) ? DEP : len;
        m = (L < ab) ? L : ab;
        @(negedge clk);
        start     = 1'b1;
        abort     = (ab == 0);
        base_addr = base;
        length    = LW'(len);
        for (int c = 1; c <= L + 7; c++) begin
            @(negedge clk);
            start = hold && (c <= L);
            abort = (c == ab);
            if (hold) begin
                base_addr = ~base;
                length    = LW'(7);
            end
            cur_cyc = c;
            for (int g = 0; g < NI; g++) begin
                lat = g + 1;
                cur_lat = lat;
                if (c <= m)     ea = base + AW'(c - 1);
                else if (m > 0) ea = base + AW'(m - 1);
                else            ea = exp_addr[g];
                chk("addr", 32'(address[g]), 32'(ea));
                chk("busy", 32'(busy[g]), 32'(L > 0 && c <= L + lat && c <= ab));
                t = (L == 0) ? 1 : L + lat + 1;
                chk("done", 32'(done[g]), 32'(c >= t && c <= ab));
                v = (L > 0 && c >= 2 + lat && c <= 1 + L + lat && c <= ab);
                chk("out_valid", 32'(out_valid[g]), 32'(v));
                if (v) begin
                    i = c - 2 - lat;
                    chk("out_data", 32'(out_data[g]), 32'(rom_fn(base + AW'(i))));
                    chk("out_index", 32'(out_index[g]), 32'(i));
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        for (int g = 0; g < NI; g++) begin
            lat = g + 1;
            cur_lat = lat;
            for (int k = 0; k < L; k++) begin
                if (1 + k + lat <= ab) exp_mem[g][k] = rom_fn(base + AW'(k));
            end
            if (m > 0) exp_addr[g] = base + AW'(m - 1);
            for (int k = 0; k < DEP; k++) begin
                chk("rom_data", 32'(rom_data[g][k]), 32'(exp_mem[g][k]));
            end
        end
    endtask

    task automatic chk_all_zero(input bit with_mem);
        for (int g = 0; g < NI; g++) begin
            cur_lat = g + 1;
            chk("rst_addr", 32'(address[g]), 32'd0);
            chk("rst_busy", 32'(busy[g]), 32'd0);
            chk("rst_done", 32'(done[g]), 32'd0);
            chk("rst_out_valid", 32'(out_valid[g]), 32'd0);
            chk("rst_out_data", 32'(out_data[g]), 32'd0);
            chk("rst_out_index", 32'(out_index[g]), 32'd0);
            if (with_mem) begin
                for (int k = 0; k < DEP; k++) begin
                    chk("rst_rom_data", 32'(rom_data[g][k]), 32'd0);
                end
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cur_lat   = 0;
        cur_cyc   = 0;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        base_addr = '0;
        length    = '0;
        for (int g = 0; g < NI; g++) begin
            exp_mem[g]  = '0;
            exp_addr[g] = '0;
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_all_zero(1'b1);

        run_burst(9'h000, 32, NONE, 1'b0);   // full array, done at L+RD_LAT+1
        run_burst(9'h1FE, 4,  NONE, 1'b1);   // address wrap, start held while busy
        run_burst(9'h010, 0,  NONE, 1'b0);   // empty burst
        run_burst(9'h020, 40, NONE, 1'b0);   // length clamped to DEP
        run_burst(9'h100, 16, 5,    1'b0);   // abort mid-burst
        run_burst(9'h040, 3,  NONE, 1'b0);   // from IDLE, upper entries retained
        run_burst(9'h050, 5,  0,    1'b0);   // start+abort together from DONE
        run_burst(9'h060, 2,  NONE, 1'b0);   // IDLE after start+abort

        // Reset while the slowest instance is draining.
        @(negedge clk);
        start     = 1'b1;
        base_addr = 9'h00A;
        length    = LW'(4);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            reset = (c == 5);
        end
        for (int c = 6; c <= 10; c++) begin
            @(negedge clk);
            reset   = 1'b0;
            cur_cyc = c;
            chk_all_zero(c == 6 || c == 10);
        end
        for (int g = 0; g < NI; g++) begin
            exp_mem[g]  = '0;
            exp_addr[g] = '0;
        end

        run_burst(9'h1F0, 2, NONE, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
